// File: rtl/tqvp_nkanderson_wdt_sched_if.sv
// TinyQV peripheral register bus between the CPU and the WDT scheduler.
// The CPU side is the master; the scheduler is the slave.
interface tqvp_nkanderson_wdt_sched_if;
   logic [5:0]  address;
   logic [31:0] data_in;
   logic [1:0]  data_write_n;
   logic [1:0]  data_read_n;
   logic [31:0] data_out;
   logic        data_ready;

   modport master (
      output address, data_in, data_write_n, data_read_n,
      input  data_out, data_ready
   );

   modport slave (
      input  address, data_in, data_write_n, data_read_n,
      output data_out, data_ready
   );
endinterface

// File: rtl/tqvp_nkanderson_wdt_sched.sv
// Watchdog scheduler: programs the WDT and taps it once all masked clients check in.
// Optional round counter at address 6 when TQVP_WDT_SCHED_ROUND_CNT_EN is defined.
module tqvp_nkanderson_wdt_sched #(
   parameter int          NUM_CLIENTS = 4,
   parameter logic [31:0] TAP_MAGIC   = 32'h0000ABCD,
   parameter logic [15:0] CHECKIN_KEY = 16'hC0DE
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  ui_in,
   output logic [7:0]  uo_out,
   tqvp_nkanderson_wdt_sched_if.slave bus,
   output logic        user_interrupt,
   output logic [5:0]  wdt_address,
   output logic [31:0] wdt_data,
   output logic [1:0]  wdt_write_n,
   input  logic        wdt_timeout
);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_CFG_CNT   = 3'd1,
      S_CFG_START = 3'd2,
      S_CFG_TAP   = 3'd3,
      S_RUN       = 3'd4,
      S_TAP       = 3'd5,
      S_DIS       = 3'd6,
      S_FAULT     = 3'd7
   } state_t;

   state_t                 state, state_n;
   logic [31:0]            timeout;
   logic [NUM_CLIENTS-1:0] mask;
   logic [NUM_CLIENTS-1:0] pending, pending_n;
   logic                   fault;
   logic [31:0]            wdata;
   logic [7:0]             id_hot;
   logic [7:0]             pend8;
   logic [2:0]             st;
   logic                   wr, arm, disarm, do_arm, do_disarm;
   logic                   live, checkin, all_in, timeout_hit;
   logic                   unused;

   assign st          = state;
   assign wr          = bus.data_write_n != 2'b11;
   assign arm         = wr && bus.address == 6'd0 && wdata[0];
   assign disarm      = wr && bus.address == 6'd0 && wdata[1];
   assign live        = state == S_RUN || state == S_TAP;
   assign do_disarm   = disarm && state != S_IDLE;
   assign do_arm      = arm && !disarm && timeout != 32'd0 &&
                        (state == S_IDLE || state == S_FAULT);
   assign id_hot      = 8'd1 << bus.data_in[2:0];
   assign checkin     = wr && bus.address == 6'd3 && live &&
                        bus.data_in[31:16] == CHECKIN_KEY;
   assign all_in      = mask != '0 && (pending & mask) == mask;
   assign timeout_hit = wdt_timeout && live;
   assign pend8       = 8'(pending);

   assign user_interrupt = fault;
   assign uo_out         = {st, fault, pend8[3:0]};
   assign unused         = &{1'b0, ui_in, pend8[7:4]};

   // Zero-extend narrow writes to a full word.
   always_comb begin
      wdata = bus.data_in;
      case (bus.data_write_n)
         2'b00:   wdata = {24'd0, bus.data_in[7:0]};
         2'b01:   wdata = {16'd0, bus.data_in[15:0]};
         default: wdata = bus.data_in;
      endcase
   end

   // Next-state logic; disarm outranks arm and everything else.
   always_comb begin
      state_n = state;
      if (do_disarm) begin
         state_n = S_DIS;
      end else if (do_arm) begin
         state_n = S_CFG_CNT;
      end else begin
         case (state)
            S_CFG_CNT:   state_n = S_CFG_START;
            S_CFG_START: state_n = S_CFG_TAP;
            S_CFG_TAP:   state_n = S_RUN;
            S_RUN: begin
               if (timeout_hit)  state_n = S_FAULT;
               else if (all_in)  state_n = S_TAP;
            end
            S_TAP:       state_n = timeout_hit ? S_FAULT : S_RUN;
            S_DIS:       state_n = S_IDLE;
            default:     state_n = state;
         endcase
      end
   end

   // WDT write port is a pure function of the current state.
   always_comb begin
      wdt_address = 6'd0;
      wdt_data    = 32'd0;
      wdt_write_n = 2'b11;
      case (state)
         S_CFG_CNT: begin
            wdt_address = 6'd2;
            wdt_data    = timeout;
            wdt_write_n = 2'b10;
         end
         S_CFG_START: begin
            wdt_address = 6'd1;
            wdt_data    = 32'd1;
            wdt_write_n = 2'b10;
         end
         S_CFG_TAP, S_TAP: begin
            wdt_address = 6'd3;
            wdt_data    = TAP_MAGIC;
            wdt_write_n = 2'b10;
         end
         S_DIS: begin
            wdt_address = 6'd0;
            wdt_data    = 32'd0;
            wdt_write_n = 2'b10;
         end
         default: ;
      endcase
   end

   // Pending: round clear first, so a check-in during TAP survives.
   always_comb begin
      pending_n = pending;
      if (state == S_TAP || do_arm || do_disarm) pending_n = '0;
      if (checkin) pending_n = pending_n | id_hot[NUM_CLIENTS-1:0];
   end

   // State, configuration registers, pending and sticky fault.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         timeout <= 32'd0;
         mask    <= '0;
         pending <= '0;
         fault   <= 1'b0;
      end else begin
         state   <= state_n;
         pending <= pending_n;
         if (wr && bus.address == 6'd1) timeout <= wdata;
         if (wr && bus.address == 6'd2) mask <= wdata[NUM_CLIENTS-1:0];
         if (do_arm) fault <= 1'b0;
         else if (state_n == S_FAULT && state != S_FAULT) fault <= 1'b1;
      end
   end

`ifdef TQVP_WDT_SCHED_ROUND_CNT_EN
   logic [15:0] rounds;

   // Completed tap rounds since the last arm, saturating.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rounds <= 16'd0;
      else if (do_arm) rounds <= 16'd0;
      else if (state == S_TAP && rounds != 16'hFFFF) rounds <= rounds + 16'd1;
   end
`endif

   // Combinational register read mux.
   always_comb begin
      bus.data_ready = bus.data_read_n != 2'b11;
      bus.data_out   = 32'hFFFFFFFF;
      case (bus.address)
         6'd0:    bus.data_out = 32'd0;
         6'd1:    bus.data_out = timeout;
         6'd2:    bus.data_out = 32'(mask);
         6'd3:    bus.data_out = 32'd0;
         6'd4:    bus.data_out = {24'd0, st, 3'd0, fault, live};
         6'd5:    bus.data_out = 32'(pending);
`ifdef TQVP_WDT_SCHED_ROUND_CNT_EN
         6'd6:    bus.data_out = {16'd0, rounds};
`endif
         default: bus.data_out = 32'hFFFFFFFF;
      endcase
   end

endmodule

// File: tb/tb_tqvp_nkanderson_wdt_sched.sv
// Self-checking bench for the WDT scheduler.
// A negedge monitor pops expected WDT writes from a scoreboard queue.
module tb_tqvp_nkanderson_wdt_sched;

   typedef struct {
      logic [5:0]  a;
      logic [31:0] d;
   } wr_t;

   logic        clk;
   logic        rst_n;
   logic [7:0]  ui_in;
   logic [7:0]  uo_out;
   logic        user_interrupt;
   logic [5:0]  wdt_address;
   logic [31:0] wdt_data;
   logic [1:0]  wdt_write_n;
   logic        wdt_timeout;

   int  n_checks;
   int  n_fail;
   wr_t exp_q[$];
   wr_t mon_e;

   tqvp_nkanderson_wdt_sched_if bus ();

   tqvp_nkanderson_wdt_sched dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .ui_in          (ui_in),
      .uo_out         (uo_out),
      .bus            (bus.slave),
      .user_interrupt (user_interrupt),
      .wdt_address    (wdt_address),
      .wdt_data       (wdt_data),
      .wdt_write_n    (wdt_write_n),
      .wdt_timeout    (wdt_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wr(input logic [5:0] a, input logic [31:0] d, input logic [1:0] sz);
      bus.address      = a;
      bus.data_in      = d;
      bus.data_write_n = sz;
      @(posedge clk);
      #1;
      bus.data_write_n = 2'b11;
   endtask

   task automatic rd(input logic [5:0] a, output logic [31:0] d, output logic rdy);
      bus.address     = a;
      bus.data_read_n = 2'b10;
      #1;
      d   = bus.data_out;
      rdy = bus.data_ready;
      @(posedge clk);
      #1;
      bus.data_read_n = 2'b11;
   endtask

   task automatic push(input logic [5:0] a, input logic [31:0] d);
      wr_t e;
      e.a = a;
      e.d = d;
      exp_q.push_back(e);
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 10 && exp_q.size() != 0; i++) step(1);
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL %s: %0d WDT writes still outstanding, required 0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_reset();
      logic [31:0] d;
      logic        rdy;
      rst_n = 1'b0;
      step(3);
      n_checks++;
      if (wdt_write_n !== 2'b11 || wdt_address !== 6'd0 || wdt_data !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_wdt: got %b/%0d/%h, required 11/0/0", wdt_write_n, wdt_address, wdt_data);
      end
      rst_n = 1'b1;
      step(1);
      n_checks++;
      if (uo_out !== 8'd0) begin
         n_fail++;
         $display("FAIL reset_uo_out: got %h, required 00", uo_out);
      end
      n_checks++;
      if (user_interrupt !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_irq: got %b, required 0", user_interrupt);
      end
      rd(6'd4, d, rdy);
      n_checks++;
      if (d !== 32'd0 || rdy !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_status: got %h rdy=%b, required 00000000 rdy=1", d, rdy);
      end
      rd(6'd9, d, rdy);
      n_checks++;
      if (d !== 32'hFFFFFFFF) begin
         n_fail++;
         $display("FAIL unmapped_read: got %h, required FFFFFFFF", d);
      end
   endtask

   task automatic test_arm();
      logic [31:0] d;
      logic        rdy;
      wr(6'd1, 32'hFFFFFF64, 2'b00);
      rd(6'd1, d, rdy);
      n_checks++;
      if (d !== 32'd100) begin
         n_fail++;
         $display("FAIL timeout_zext: got %h, required 00000064", d);
      end
      wr(6'd2, 32'd3, 2'b10);
      push(6'd2, 32'd100);
      push(6'd1, 32'd1);
      push(6'd3, 32'h0000ABCD);
      wr(6'd0, 32'd1, 2'b10);
      n_checks++;
      if (wdt_write_n !== 2'b10 || wdt_address !== 6'd2) begin
         n_fail++;
         $display("FAIL arm_cfg_cnt: got %b/%0d, required 10/2", wdt_write_n, wdt_address);
      end
      step(1);
      n_checks++;
      if (wdt_write_n !== 2'b10 || wdt_address !== 6'd1) begin
         n_fail++;
         $display("FAIL arm_cfg_start: got %b/%0d, required 10/1", wdt_write_n, wdt_address);
      end
      step(1);
      n_checks++;
      if (wdt_write_n !== 2'b10 || wdt_address !== 6'd3) begin
         n_fail++;
         $display("FAIL arm_cfg_tap: got %b/%0d, required 10/3", wdt_write_n, wdt_address);
      end
      step(1);
      n_checks++;
      if (wdt_write_n !== 2'b11) begin
         n_fail++;
         $display("FAIL arm_idle_port: got %b, required 11", wdt_write_n);
      end
      drain("arm_seq");
      rd(6'd4, d, rdy);
      n_checks++;
      if (d[7:5] !== 3'd4 || d[1] !== 1'b0) begin
         n_fail++;
         $display("FAIL arm_state: got status %h, required state 4 fault 0", d);
      end
   endtask

   task automatic test_checkin();
      logic [31:0] d;
      logic        rdy;
      wr(6'd3, 32'hC0DE0000, 2'b10);
      rd(6'd5, d, rdy);
      n_checks++;
      if (d !== 32'd1) begin
         n_fail++;
         $display("FAIL checkin_id0: got %h, required 00000001", d);
      end
      push(6'd3, 32'h0000ABCD);
      wr(6'd3, 32'hC0DE0001, 2'b10);
      drain("tap_round");
      step(1);
      rd(6'd5, d, rdy);
      n_checks++;
      if (d !== 32'd0) begin
         n_fail++;
         $display("FAIL tap_clears_pending: got %h, required 00000000", d);
      end
      wr(6'd3, 32'hC0DE0000, 2'b10);
      step(5);
      wr(6'd3, 32'hC0DE0007, 2'b10);
      wr(6'd3, 32'h12340001, 2'b10);
      step(2);
      rd(6'd5, d, rdy);
      n_checks++;
      if (d !== 32'd1) begin
         n_fail++;
         $display("FAIL bad_checkin: got %h, required 00000001", d);
      end
   endtask

   task automatic test_rounds();
      logic [31:0] d;
      logic        rdy;
      logic [31:0] want;
      for (int r = 0; r < 4; r++) begin
         wr(6'd3, 32'hC0DE0000, 2'b10);
         push(6'd3, 32'h0000ABCD);
         wr(6'd3, 32'hC0DE0001, 2'b10);
         drain("round_tap");
         step(1);
      end
`ifdef TQVP_WDT_SCHED_ROUND_CNT_EN
      want = 32'd5;
`else
      want = 32'hFFFFFFFF;
`endif
      rd(6'd6, d, rdy);
      n_checks++;
      if (d !== want) begin
         n_fail++;
         $display("FAIL round_count: got %h, required %h", d, want);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] d;
      logic        rdy;
      wr(6'd3, 32'hC0DE0000, 2'b10);
      push(6'd3, 32'h0000ABCD);
      wr(6'd3, 32'hC0DE0001, 2'b10);
      step(1);
      wr(6'd3, 32'hC0DE0000, 2'b10);
      drain("b2b_tap");
      rd(6'd5, d, rdy);
      n_checks++;
      if (d !== 32'd1) begin
         n_fail++;
         $display("FAIL checkin_in_tap: got %h, required 00000001", d);
      end
   endtask

   task automatic test_mask_zero();
      logic [31:0] d;
      logic        rdy;
      wr(6'd2, 32'd0, 2'b10);
      wr(6'd3, 32'hC0DE0001, 2'b10);
      step(6);
      rd(6'd5, d, rdy);
      n_checks++;
      if (d !== 32'd3) begin
         n_fail++;
         $display("FAIL mask_zero_no_tap: got pending %h, required 00000003", d);
      end
      push(6'd3, 32'h0000ABCD);
      wr(6'd2, 32'd3, 2'b01);
      drain("mask_change_tap");
   endtask

   task automatic test_disarm();
      logic [31:0] d;
      logic        rdy;
      push(6'd0, 32'd0);
      wr(6'd0, 32'd3, 2'b10);
      drain("disarm_write");
      step(1);
      rd(6'd4, d, rdy);
      n_checks++;
      if (d !== 32'd0 || uo_out !== 8'd0) begin
         n_fail++;
         $display("FAIL disarm_idle: got status %h uo %h, required 0/0", d, uo_out);
      end
      wr(6'd1, 32'd0, 2'b10);
      wr(6'd0, 32'd1, 2'b10);
      wdt_timeout = 1'b1;
      step(4);
      wdt_timeout = 1'b0;
      rd(6'd4, d, rdy);
      n_checks++;
      if (d !== 32'd0 || user_interrupt !== 1'b0) begin
         n_fail++;
         $display("FAIL arm_zero_timeout: got status %h irq %b, required 0/0", d, user_interrupt);
      end
      wr(6'd1, 32'd100, 2'b10);
   endtask

   task automatic test_fault();
      logic [31:0] d;
      logic        rdy;
      push(6'd2, 32'd100);
      push(6'd1, 32'd1);
      push(6'd3, 32'h0000ABCD);
      wr(6'd0, 32'd1, 2'b10);
      drain("rearm_seq");
      wdt_timeout = 1'b1;
      step(1);
      n_checks++;
      if (user_interrupt !== 1'b1 || uo_out[7:4] !== 4'hF) begin
         n_fail++;
         $display("FAIL fault_entry: got irq %b uo %h, required 1/Fx", user_interrupt, uo_out);
      end
      step(3);
      wdt_timeout = 1'b0;
      rd(6'd4, d, rdy);
      n_checks++;
      if (d !== 32'h000000E2) begin
         n_fail++;
         $display("FAIL fault_status: got %h, required 000000E2", d);
      end
      push(6'd2, 32'd100);
      push(6'd1, 32'd1);
      push(6'd3, 32'h0000ABCD);
      wr(6'd0, 32'd1, 2'b10);
      drain("fault_rearm");
      n_checks++;
      if (user_interrupt !== 1'b0) begin
         n_fail++;
         $display("FAIL fault_cleared: got %b, required 0", user_interrupt);
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] d;
      logic        rdy;
      push(6'd0, 32'd0);
      wr(6'd0, 32'd2, 2'b10);
      drain("pre_reset_disarm");
      step(1);
      wr(6'd0, 32'd1, 2'b10);
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (wdt_write_n !== 2'b11 || wdt_address !== 6'd0) begin
         n_fail++;
         $display("FAIL reset_mid: got %b/%0d, required 11/0", wdt_write_n, wdt_address);
      end
      step(2);
      rst_n = 1'b1;
      step(1);
      rd(6'd1, d, rdy);
      n_checks++;
      if (d !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_timeout: got %h, required 00000000", d);
      end
   endtask

   initial begin
      n_checks         = 0;
      n_fail           = 0;
      rst_n            = 1'b0;
      ui_in            = 8'd0;
      wdt_timeout      = 1'b0;
      bus.address      = 6'd0;
      bus.data_in      = 32'd0;
      bus.data_write_n = 2'b11;
      bus.data_read_n  = 2'b11;
      fork
         forever begin
            @(negedge clk);
            if (rst_n && wdt_write_n !== 2'b11) begin
               n_checks++;
               if (exp_q.size() == 0) begin
                  n_fail++;
                  $display("FAIL wdt_write: got unexpected %b addr=%0d data=%h, required none",
                           wdt_write_n, wdt_address, wdt_data);
               end else begin
                  mon_e = exp_q.pop_front();
                  if (wdt_write_n !== 2'b10 || wdt_address !== mon_e.a || wdt_data !== mon_e.d) begin
                     n_fail++;
                     $display("FAIL wdt_write: got %b addr=%0d data=%h, required 10 addr=%0d data=%h",
                              wdt_write_n, wdt_address, wdt_data, mon_e.a, mon_e.d);
                  end
               end
            end
         end
      join_none
      test_reset();
      test_arm();
      test_checkin();
      test_rounds();
      test_back_to_back();
      test_mask_zero();
      test_disarm();
      test_fault();
      test_reset_mid();
      step(2);
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL final_queue: got %0d outstanding, required 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
